// File: rtl/neuron_acc_pkg.sv
// ---------------------------------------------------------------------------
// neuron_acc_pkg
// Shared definitions for the Q8.8 neuron pipeline (mult, accumulator and the
// later neuron stages): data format constants, saturation limits and the
// accumulator FSM state type.
// ---------------------------------------------------------------------------
package neuron_acc_pkg;

  // Q8.8 data format: 16-bit two's complement, 8 fractional bits
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int CNT_W  = 8;

  // Largest positive and most negative representable Q8.8 values
  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

  // IDLE: no group open, ACC: group open, HOLD: result waiting for downstream
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } acc_state_t;

  // Beat counter increment that sticks at its maximum instead of wrapping
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end
    return c + 1'b1;
  endfunction

endpackage

// File: rtl/neuron_acc_q88_sat.sv
// ---------------------------------------------------------------------------
// q88_sat
// Combinational conversion of a wide signed accumulator value to Q8.8:
// clamps to [0x8000, 0x7FFF], then optionally applies ReLU.
//
// Ports
//   acc      : signed accumulator value, ACC_W bits (ACC_W must exceed 16)
//   relu_en  : 1 = negative results become 0x0000
//   q        : 16-bit Q8.8 result
// ---------------------------------------------------------------------------
module q88_sat
  import neuron_acc_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic                     relu_en,
  output logic        [DATA_W-1:0] q
);

  // Q8.8 limits sign-extended to the accumulator width for signed compares
  localparam logic signed [ACC_W-1:0] ACC_HI = {{(ACC_W-DATA_W){1'b0}}, Q_MAX};
  localparam logic signed [ACC_W-1:0] ACC_LO = {{(ACC_W-DATA_W){1'b1}}, Q_MIN};

  // Clamp first, then ReLU on the clamped value
  always_comb begin
    q = acc[DATA_W-1:0];
    if (acc > ACC_HI) begin
      q = Q_MAX;
    end else if (acc < ACC_LO) begin
      q = Q_MIN;
    end
    if (relu_en && q[DATA_W-1]) begin
      q = '0;
    end
  end

endmodule

// File: rtl/neuron_acc.sv
// ---------------------------------------------------------------------------
// neuron_acc
// Accumulates a group of signed Q8.8 product beats into a wide wrapping
// accumulator and reports the saturated (optionally ReLU'd) sum together with
// the beat count. One result is held at a time; input is stalled while the
// result waits for the downstream stage.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   clear      : synchronous abort of the open group / pending result
//   in_data    : signed Q8.8 beat
//   in_valid   : in_data valid
//   in_last    : final beat of the group
//   in_ready   : block can accept a beat (0 while a result is pending)
//   out_data   : registered Q8.8 neuron result
//   out_cnt    : registered beat count of the reported group (saturates 255)
//   out_valid  : out_data / out_cnt valid
//   out_ready  : downstream accepts the result
// ---------------------------------------------------------------------------
module neuron_acc
  import neuron_acc_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int RELU  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_valid,
  input  logic              out_ready
);

  acc_state_t               state;
  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  cnt;

  logic signed [ACC_W-1:0]  beat_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic        [CNT_W-1:0]  cnt_next;
  logic        [DATA_W-1:0] sat_q;
  logic                     accept;

  assign in_ready = (state != ST_HOLD);
  assign accept   = in_valid && in_ready;
  assign beat_ext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

  // The first beat of a group loads the accumulator; later beats add to it
  always_comb begin
    acc_next = beat_ext;
    cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
    if (state == ST_ACC) begin
      acc_next = acc + beat_ext;
      cnt_next = cnt_sat_inc(cnt);
    end
  end

  // Converting the post-beat sum lets the result register on the same edge
  // that accepts the last beat, giving one cycle of latency
  q88_sat #(
    .ACC_W (ACC_W)
  ) u_sat (
    .acc     (acc_next),
    .relu_en (RELU != 0),
    .q       (sat_q)
  );

  // clear outranks any beat or output handshake in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACC: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (in_last) begin
              state     <= ST_HOLD;
              out_data  <= sat_q;
              out_cnt   <= cnt_next;
              out_valid <= 1'b1;
            end else begin
              state <= ST_ACC;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_acc.sv
// ---------------------------------------------------------------------------
// tb_neuron_acc
// Drives one RELU=1 and one RELU=0 instance from shared inputs and checks both
// against a group-sum reference model on every cycle, plus directed cases with
// hand-computed results.
// ---------------------------------------------------------------------------
module tb_neuron_acc;

  localparam int ACC_W = 24;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_r, in_ready_l;
  logic [15:0] out_data_r, out_data_l;
  logic [7:0]  out_cnt_r, out_cnt_l;
  logic        out_valid_r, out_valid_l;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  neuron_acc #(.ACC_W(ACC_W), .RELU(1)) dut_relu (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_r),
    .out_data  (out_data_r),
    .out_cnt   (out_cnt_r),
    .out_valid (out_valid_r),
    .out_ready (out_ready)
  );

  neuron_acc #(.ACC_W(ACC_W), .RELU(0)) dut_lin (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_l),
    .out_data  (out_data_l),
    .out_cnt   (out_cnt_l),
    .out_valid (out_valid_l),
    .out_ready (out_ready)
  );

  // Reference model: plain integer sum of the group, wrapped to ACC_W bits,
  // clamped to Q8.8 and optionally ReLU'd when the group closes
  longint      m_sum = 0;
  int          m_n = 0;
  bit          m_hold = 1'b0;
  logic [15:0] m_relu = 16'h0000;
  logic [15:0] m_lin = 16'h0000;
  logic [7:0]  m_cnt = 8'h00;

  function automatic logic [15:0] to_q88(input longint s, input bit relu);
    longint one;
    longint w;
    logic [15:0] r;
    one = 1;
    w = s & ((one << ACC_W) - 1);
    if (w >= (one << (ACC_W - 1))) w = w - (one << ACC_W);
    if (w > 32767) r = 16'h7FFF;
    else if (w < -32768) r = 16'h8000;
    else r = w[15:0];
    if (relu && r[15]) r = 16'h0000;
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset || clear) begin
      m_hold = 1'b0;
      m_sum  = 0;
      m_n    = 0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      m_sum = m_sum + longint'($signed(in_data));
      m_n   = m_n + 1;
      if (in_last) begin
        m_hold = 1'b1;
        m_relu = to_q88(m_sum, 1'b1);
        m_lin  = to_q88(m_sum, 1'b0);
        m_cnt  = (m_n > 255) ? 8'd255 : 8'(m_n);
        m_sum  = 0;
        m_n    = 0;
      end
    end
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  initial forever begin
    @(negedge clk);
    if (reset) begin
      compare("in_ready_relu", {31'd0, in_ready_r}, {31'd0, !m_hold});
      compare("in_ready_lin", {31'd0, in_ready_l}, {31'd0, !m_hold});
      compare("out_valid_relu", {31'd0, out_valid_r}, {31'd0, m_hold});
      compare("out_valid_lin", {31'd0, out_valid_l}, {31'd0, m_hold});
      if (m_hold) begin
        compare("out_data_relu", {16'd0, out_data_r}, {16'd0, m_relu});
        compare("out_data_lin", {16'd0, out_data_l}, {16'd0, m_lin});
        compare("out_cnt_relu", {24'd0, out_cnt_r}, {24'd0, m_cnt});
        compare("out_cnt_lin", {24'd0, out_cnt_l}, {24'd0, m_cnt});
      end
    end
  end

  // One accepted beat; inputs change 1 time unit after the rising edge
  task automatic applyStimulus(input logic [15:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Result must be present the cycle after the last beat; then handshake it
  task automatic checkOutput(input string name, input logic [15:0] exp_relu,
                             input logic [15:0] exp_lin, input logic [7:0] exp_cnt);
    @(negedge clk);
    compare({name, "_valid"}, {31'd0, out_valid_r & out_valid_l}, 32'd1);
    compare({name, "_relu"}, {16'd0, out_data_r}, {16'd0, exp_relu});
    compare({name, "_lin"}, {16'd0, out_data_l}, {16'd0, exp_lin});
    compare({name, "_cnt"}, {24'd0, out_cnt_r}, {24'd0, exp_cnt});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    compare("rst_in_ready", {31'd0, in_ready_r}, 32'd1);
    compare("rst_out_valid", {31'd0, out_valid_r | out_valid_l}, 32'd0);
    compare("rst_out_data", {16'd0, out_data_r | out_data_l}, 32'd0);
    compare("rst_out_cnt", {24'd0, out_cnt_r}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Three beats of 1.0
    applyStimulus(16'h0100, 1'b0);
    applyStimulus(16'h0100, 1'b0);
    applyStimulus(16'h0100, 1'b1);
    checkOutput("sum3", 16'h0300, 16'h0300, 8'd3);

    // 1.0 + (-2.0)
    applyStimulus(16'h0100, 1'b0);
    applyStimulus(16'hFE00, 1'b1);
    checkOutput("neg", 16'h0000, 16'hFF00, 8'd2);

    // Positive and negative saturation
    applyStimulus(16'h7FFF, 1'b0);
    applyStimulus(16'h7FFF, 1'b1);
    checkOutput("satpos", 16'h7FFF, 16'h7FFF, 8'd2);
    applyStimulus(16'h8000, 1'b0);
    applyStimulus(16'h8000, 1'b1);
    checkOutput("satneg", 16'h0000, 16'h8000, 8'd2);

    // Back-pressure: result held while in_valid is driven
    applyStimulus(16'h0040, 1'b0);
    applyStimulus(16'h0040, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      compare("hold_in_ready", {31'd0, in_ready_r}, 32'd0);
      compare("hold_data", {16'd0, out_data_r}, 32'h0080);
      compare("hold_cnt", {24'd0, out_cnt_l}, 32'd2);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    compare("release_valid", {31'd0, out_valid_r}, 32'd0);
    compare("release_ready", {31'd0, in_ready_r}, 32'd1);

    // Asynchronous reset while a result is pending
    applyStimulus(16'h0100, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    compare("async_valid", {31'd0, out_valid_r | out_valid_l}, 32'd0);
    compare("async_ready", {31'd0, in_ready_r}, 32'd1);
    compare("async_data", {16'd0, out_data_r}, 32'd0);
    compare("async_cnt", {24'd0, out_cnt_l}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset in the middle of a group discards the partial sum
    applyStimulus(16'h0100, 1'b0);
    applyStimulus(16'h0100, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(16'h0200, 1'b1);
    checkOutput("midreset", 16'h0200, 16'h0200, 8'd1);

    // clear beats a simultaneous last beat
    clear = 1'b1;
    applyStimulus(16'h0100, 1'b1);
    clear = 1'b0;
    @(negedge clk);
    compare("clear_beat_valid", {31'd0, out_valid_r | out_valid_l}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(16'h0080, 1'b1);
    checkOutput("after_clear", 16'h0080, 16'h0080, 8'd1);

    // clear discards a pending result
    applyStimulus(16'h0100, 1'b1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    compare("clear_hold_valid", {31'd0, out_valid_l}, 32'd0);
    @(posedge clk);
    #1;

    // Count saturation at 255
    for (int i = 0; i < 259; i++) applyStimulus(16'h0001, 1'b0);
    applyStimulus(16'h0001, 1'b1);
    checkOutput("cnt_sat", 16'h0104, 16'h0104, 8'd255);

    // Accumulator wrap: 300 * 0x7FFF exceeds 2^23 and wraps negative
    for (int i = 0; i < 299; i++) applyStimulus(16'h7FFF, 1'b0);
    applyStimulus(16'h7FFF, 1'b1);
    checkOutput("acc_wrap", 16'h0000, 16'h8000, 8'd255);

    // Randomized traffic checked by the per-cycle compare process
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 16'($urandom);
      in_last   = ($urandom_range(3) == 0);
      out_ready = ($urandom_range(2) == 0);
      clear     = ($urandom_range(49) == 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neuron_acc.md
NEURON_ACC -- requirements
Module: neuron_acc

Interface
REQ-001 Parameter ACC_W, default 24, gives the internal signed accumulator width in bits.
REQ-002 Parameter RELU, default 1: value 1 enables ReLU on the output; value 0 passes signed values through.
REQ-003 Port clk, input, 1 bit: the single clock. All state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: the reset. It is asynchronous and active-low, so reset=0 resets the block.
REQ-005 Port clear, input, 1 bit: synchronous abort of the group currently being accumulated.
REQ-006 Port in_data, input, 16 bits: signed Q8.8 product beat from the upstream mult stage.
REQ-007 Port in_valid, input, 1 bit: in_data is valid.
REQ-008 Port in_last, input, 1 bit: marks the final beat of a group.
REQ-009 Port in_ready, output, 1 bit: the block can accept a beat.
REQ-010 Port out_data, output, 16 bits: signed Q8.8 neuron result.
REQ-011 Port out_cnt, output, 8 bits: number of beats in the reported group.
REQ-012 Port out_valid, output, 1 bit: out_data and out_cnt are valid.
REQ-013 Port out_ready, input, 1 bit: the downstream stage accepts the result.

Function
REQ-014 All data SHALL be two's-complement Q8.8; 0x0100 represents 1.0.
REQ-015 The FSM SHALL have three states: IDLE (empty), ACC (group open) and HOLD (result pending).
REQ-016 in_ready SHALL be 1 in IDLE and ACC, and SHALL be 0 in HOLD.
REQ-017 A beat is accepted only when in_valid && in_ready. When in_ready=0, in_valid SHALL be ignored.
REQ-018 A beat accepted in IDLE SHALL load acc <= sext(in_data) and cnt <= 1.
REQ-019 A beat accepted in ACC SHALL set acc <= acc + sext(in_data), wrapping modulo 2^ACC_W, and cnt <= cnt + 1, saturating at 255.
REQ-020 Transitions: IDLE->ACC on an accepted beat with in_last=0; IDLE->HOLD on an accepted beat with in_last=1; ACC->HOLD on an accepted beat with in_last=1.
REQ-021 out_data and out_cnt SHALL be registered, with out_valid=1 on the cycle after the last beat is accepted (latency 1).
REQ-022 Output conversion: a final acc above 0x7FFF SHALL give 0x7FFF; a final acc below -0x8000 SHALL give 0x8000. Otherwise out_data takes the low 16 bits. Then, if RELU=1, any negative value SHALL give 0x0000.
REQ-023 In HOLD, out_data, out_cnt and out_valid SHALL remain stable until out_ready=1.
REQ-024 On out_valid && out_ready the block SHALL go HOLD->IDLE and drop out_valid next cycle; in_ready returns to 1 in that same next cycle.
REQ-025 clear=1 SHALL force IDLE, acc=0, cnt=0 and out_valid=0 next cycle, in any state. clear has priority over a simultaneous beat or handshake, and discards any pending result.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, acc=0, cnt=0, out_data=0x0000, out_cnt=0 and out_valid=0. in_ready is therefore 1 after reset.
REQ-027 A reset in the middle of a group SHALL discard the partial sum; no output is produced for that group.

Structure
REQ-028 A shared package SHALL hold: DATA_W=16, FRAC_W=8, Q_MAX=0x7FFF, Q_MIN=0x8000 and the FSM state enum. These are shared with mult and the later neuron stages.
REQ-029 The saturation and ReLU conversion SHALL be a single combinational sub-module, q88_sat (ACC_W-bit input, 16-bit output, relu_en input).

Verification
REQ-030 Beats 0x0100, 0x0100, 0x0100(last) -> out_data=0x0300, out_cnt=3, out_valid one cycle after the last beat.
REQ-031 Beats 0x0100, 0xFE00(last): with RELU=1 -> 0x0000; with RELU=0 -> 0xFF00.
REQ-032 Beats 0x7FFF, 0x7FFF(last) -> 0x7FFF. Beats 0x8000, 0x8000(last) with RELU=0 -> 0x8000.
REQ-033 Hold out_ready=0 for 5 cycles after a result while driving in_valid=1 -> out_data and out_valid stable, in_ready=0, no beats absorbed; raising out_ready -> IDLE the next cycle.
REQ-034 Drive reset=0 after 2 beats of 0x0100, then send 0x0200(last) -> out_data=0x0200, out_cnt=1.
REQ-035 Assert clear together with a last beat 0x0100 -> no out_valid; the next group 0x0080(last) -> 0x0080, out_cnt=1.
